// File: rtl/game_pkg.sv
// ============================================================================
// Module : game_pkg
// Brief  : Shared constants for the reaction game: channel map, player
//          indices and red-light colour encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int NUM_CH   = 5;
    localparam int CH_RED   = 4;

    localparam int PLAYER_0 = 0;
    localparam int PLAYER_1 = 1;
    localparam int PLAYER_2 = 2;
    localparam int PLAYER_3 = 3;

    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b11;
    localparam logic [1:0] RED    = 2'b10;

    // Width of the optional per-channel hold counter.
    localparam int HOLD_W = 16;

    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ============================================================================
// Module : debounce_ch
// Brief  : One input channel: 2-flop synchronizer, debounce counter, stable
//          level, press/release pulses and, when CLICK_STUCK_DETECT_EN is
//          defined, a saturating hold counter driving a stuck flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_ch
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o,
    output logic stuck_o
);

    localparam int             CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q;
    logic             s_q;
    logic             stable_q;
    logic             stable_d;
    logic             press_q;
    logic             release_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the sample disagrees with the stable level;
    // any agreeing sample restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = s_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            s_q       <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= stable_d & ~stable_q;
            release_q <= ~stable_d & stable_q;
        end
    end

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef CLICK_STUCK_DETECT_EN
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] STUCK_THR  = HOLD_W'(STUCK_CYCLES);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              stuck_q;

    // Counting on the next stable value makes the edge where stable rises
    // count as the first held cycle.
    always_comb begin
        hold_d = '0;
        if (stable_d) begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            stuck_q <= stable_d && (hold_d >= STUCK_THR);
        end
    end

    assign stuck_o = stuck_q;
`else
    logic [HOLD_W-1:0] w_unused_stuck_cfg;
    assign w_unused_stuck_cfg = HOLD_W'(STUCK_CYCLES);
    assign stuck_o            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module : input_conditioner
// Brief  : Debounces four player buttons and the light-cycle button, producing
//          levels, press/release pulses and optional stuck flags
//          (CLICK_STUCK_DETECT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        raw_click,
    input  logic              raw_red_toggle,
    output logic [3:0]        click,
    output logic              red_toggle,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] stuck
);

    ch_vec_t w_raw;
    ch_vec_t w_stable;

    assign w_raw = {raw_red_toggle, raw_click};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES)
        ) u_debounce_ch (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (w_raw[g]),
            .stable_o  (w_stable[g]),
            .press_o   (press_pulse[g]),
            .release_o (release_pulse[g]),
            .stuck_o   (stuck[g])
        );
    end

    assign click      = w_stable[PLAYER_3:PLAYER_0];
    assign red_toggle = w_stable[CH_RED];

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module : tb_input_conditioner
// Brief  : Self-checking bench for input_conditioner against a sample-history
//          reference model; stuck expectations follow CLICK_STUCK_DETECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_input_conditioner;

    localparam int D     = 4;
    localparam int STUCK = 10;
`ifdef CLICK_STUCK_DETECT_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] raw_click;
    logic       raw_red_toggle;
    logic [3:0] click;
    logic       red_toggle;
    logic [4:0] press_pulse;
    logic [4:0] release_pulse;
    logic [4:0] stuck;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .STUCK_CYCLES    (STUCK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .raw_click      (raw_click),
        .raw_red_toggle (raw_red_toggle),
        .click          (click),
        .red_toggle     (red_toggle),
        .press_pulse    (press_pulse),
        .release_pulse  (release_pulse),
        .stuck          (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: hist[j] is the raw value captured j+1 edges ago. The sample
    // judged at an edge is two edges old, so the last D judged samples are
    // hist[1..D]; stable flips when all of them oppose it.
    logic [4:0] hist[$];
    logic [4:0] m_stable, m_press, m_release, m_stuck;
    int         hold[5];

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j <= D; j++) hist.push_back(5'b0);
        m_stable = '0; m_press = '0; m_release = '0; m_stuck = '0;
        for (int c = 0; c < 5; c++) hold[c] = 0;
    endtask

    task automatic model_step(input logic [4:0] raw);
        logic [4:0] nxt;
        bit         all_diff;
        nxt = m_stable;
        for (int c = 0; c < 5; c++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
                if (hist[j][c] == m_stable[c]) all_diff = 1'b0;
            if (all_diff) nxt[c] = ~m_stable[c];
        end
        m_press   = nxt & ~m_stable;
        m_release = ~nxt & m_stable;
        m_stable  = nxt;
        for (int c = 0; c < 5; c++) begin
            hold[c]    = nxt[c] ? ((hold[c] < 65535) ? hold[c] + 1 : hold[c]) : 0;
            m_stuck[c] = STUCK_EN && nxt[c] && (hold[c] >= STUCK);
        end
        hist.push_front(raw);
        void'(hist.pop_back());
    endtask

    task automatic cycle(input logic [4:0] raw, input logic rst_v);
        @(negedge clk);
        raw_click      = raw[3:0];
        raw_red_toggle = raw[4];
        rst            = rst_v;
        @(posedge clk);
        if (rst_v) model_reset();
        else       model_step(raw);
        #1;
        check("level",   {red_toggle, click}, m_stable);
        check("press",   press_pulse,         m_press);
        check("release", release_pulse,       m_release);
        check("stuck",   stuck,               m_stuck);
    endtask

    logic [4:0] cur;
    logic [4:0] seen;
    int         left[5];
    int         cnt;
    int         at;
    bit         found;

    initial begin
        raw_click = '0; raw_red_toggle = 1'b0; rst = 1'b1;
        model_reset();

        repeat (3) cycle(5'b00000, 1'b1);
        check("reset_outputs", {red_toggle, click} | press_pulse | release_pulse | stuck, 5'b0);

        // Hold click[0]: rises after edge 5, pulse gone after edge 6.
        for (int i = 0; i <= 5; i++) cycle(5'b00001, 1'b0);
        check("r029_click", {4'b0, click[0]}, 5'd1);
        check("r029_press", {4'b0, press_pulse[0]}, 5'd1);
        cycle(5'b00001, 1'b0);
        check("r029_press_end", {4'b0, press_pulse[0]}, 5'd0);
        repeat (10) cycle(5'b00000, 1'b0);

        // Three-cycle glitch on click[2] is rejected.
        seen = '0;
        for (int i = 0; i < 13; i++) begin
            cycle((i < 3) ? 5'b00100 : 5'b00000, 1'b0);
            seen |= {2'b0, click[2], press_pulse[2], release_pulse[2]};
        end
        check("r030_glitch", seen, 5'b0);

        // Red and click[3] together.
        seen = '0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(5'b11000, 1'b0);
            if (press_pulse != 5'b0) begin seen = press_pulse; cnt++; end
        end
        check("r031_press", seen, 5'b11000);
        check("r031_press_cnt", 5'(cnt), 5'd1);
        check("r031_level", {red_toggle, click}, 5'b11000);
        seen = '0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(5'b00000, 1'b0);
            if (release_pulse != 5'b0) begin seen = release_pulse; cnt++; end
        end
        check("r031_release", seen, 5'b11000);
        check("r031_release_cnt", 5'(cnt), 5'd1);

        // Reset while click[1] held, then re-qualification from edge 0.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(5'b00010, 1'b0);
            found = click[1];
        end
        check("r032_first_rise", {4'b0, found}, 5'd1);
        cycle(5'b00010, 1'b1);
        check("r032_reset_clear", {red_toggle, click} | press_pulse | release_pulse, 5'b0);
        at = -1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(5'b00010, 1'b0);
            if (click[1] && at < 0) at = i;
            if (press_pulse[1]) cnt++;
        end
        check("r032_rise_edge", 5'(at), 5'd5);
        check("r032_press_cnt", 5'(cnt), 5'd1);
        repeat (8) cycle(5'b00000, 1'b0);

        // Long hold on click[0] for the stuck flag.
        at = -1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(5'b00001, 1'b0);
            if (click[0]) cnt++;
            if (stuck[0] && at < 0) at = cnt;
        end
`ifdef CLICK_STUCK_DETECT_EN
        check("r033_stuck_cycle", 5'(at), 5'd10);
`else
        check("r033_stuck_never", 5'(at + 1), 5'd0);
`endif
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(5'b00000, 1'b0);
            found = release_pulse[0];
        end
        check("r033_release", {3'b0, found, stuck[0]}, 5'b00010);

        // Continuous bouncing on every channel never settles.
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            cycle((i % 2 == 0) ? 5'b11111 : 5'b00000, 1'b0);
            seen |= {red_toggle, click} | press_pulse;
        end
        check("r021_bounce", seen, 5'b0);

        // Randomized per-channel hold lengths with occasional resets.
        cur = '0;
        for (int c = 0; c < 5; c++) left[c] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 5; c++) begin
                if (left[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 30))
                                                          : int'($urandom_range(1, 6));
                end
                left[c]--;
            end
            cycle(cur, ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
